// File: rtl/bus_xfer_ctrl.sv
// bus_xfer_ctrl: queues register-transfer commands and expands each into a
// one-hot bus source enable followed by a one-hot destination load.
module bus_xfer_ctrl #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clock,
    input  logic          clear,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [4:0]    cmd_src,
    input  logic [4:0]    cmd_dst,
    output logic [23:0]   src_out,
    output logic [23:0]   dst_in,
    output logic          busy,
    output logic          xfer_done,
    output logic          xfer_err,
    output logic [AW:0]   count
);

    typedef enum logic [1:0] {IDLE, DRIVE, LOAD, ERR} state_t;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [4:0]  MAX_CODE = 5'd23;

    state_t        state, nextState;
    logic [9:0]    fifoMem [DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    logic [AW:0]   occ;
    logic [4:0]    curSrc, curDst;
    logic [4:0]    headSrc, headDst;
    logic          doPush, doPop, headBad;

    assign headSrc   = fifoMem[rdPtr][9:5];
    assign headDst   = fifoMem[rdPtr][4:0];
    assign headBad   = (headSrc > MAX_CODE) || (headDst > MAX_CODE);
    // A full FIFO refuses a push even when a pop happens in the same cycle.
    assign doPush    = cmd_valid && (occ != FULL_CNT);
    // DRIVE is the only state that holds the current command without popping.
    assign doPop     = (occ != '0) && (state != DRIVE);
    assign cmd_ready = (occ != FULL_CNT);
    assign count     = occ;

    // Command storage; contents need no reset since occupancy gates reads.
    always_ff @(posedge clock) begin
        if (doPush && !clear) fifoMem[wrPtr] <= {cmd_src, cmd_dst};
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clock) begin
        if (clear) begin
            wrPtr <= '0;
            rdPtr <= '0;
            occ   <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            occ <= occ + {{AW{1'b0}}, doPush} - {{AW{1'b0}}, doPop};
        end
    end

    // State and current-command registers; the head is latched on every pop.
    always_ff @(posedge clock) begin
        if (clear) begin
            state  <= IDLE;
            curSrc <= '0;
            curDst <= '0;
        end else begin
            state <= nextState;
            if (doPop) begin
                curSrc <= headSrc;
                curDst <= headDst;
            end
        end
    end

    // Next state: IDLE, LOAD and ERR all pop the next command if one is queued.
    always_comb begin
        nextState = state;
        case (state)
            DRIVE:   nextState = LOAD;
            default: begin
                if (occ != '0) nextState = headBad ? ERR : DRIVE;
                else           nextState = IDLE;
            end
        endcase
    end

    // Outputs decode from registers only; invalid commands never reach DRIVE/LOAD.
    always_comb begin
        src_out   = '0;
        dst_in    = '0;
        xfer_done = 1'b0;
        xfer_err  = 1'b0;
        busy      = (state != IDLE) || (occ != '0);
        case (state)
            DRIVE: src_out = 24'd1 << curSrc;
            LOAD: begin
                src_out   = 24'd1 << curSrc;
                dst_in    = 24'd1 << curDst;
                xfer_done = 1'b1;
            end
            ERR:     xfer_err = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Bench for bus_xfer_ctrl: directed scenarios plus random traffic, all
// outputs compared every cycle against a queue-based transfer scheduler.
module tb_bus_xfer_ctrl;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clock, clear, cmd_valid, cmd_ready;
    logic [4:0]    cmd_src, cmd_dst;
    logic [23:0]   src_out, dst_in;
    logic          busy, xfer_done, xfer_err;
    logic [AW:0]   count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference: accepted commands wait in a queue; a popped valid command
    // occupies the bus for 2 cycles (drive, then drive+load), an invalid one
    // occupies 1 error cycle. A new command is popped in the last cycle of the
    // previous one, or whenever nothing is in flight.
    logic [4:0] qSrc[$];
    logic [4:0] qDst[$];
    int         slotLeft = 0;
    logic [4:0] mSrc, mDst;
    bit         mBad;

    bus_xfer_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clock(clock), .clear(clear), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .src_out(src_out), .dst_in(dst_in),
        .busy(busy), .xfer_done(xfer_done), .xfer_err(xfer_err), .count(count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic modelEdge();
        bit push, pop;
        if (clear) begin
            qSrc.delete();
            qDst.delete();
            slotLeft = 0;
            return;
        end
        push = cmd_valid && (qSrc.size() < DEPTH);
        pop  = (slotLeft <= 1) && (qSrc.size() > 0);
        if (pop) begin
            mSrc = qSrc.pop_front();
            mDst = qDst.pop_front();
            mBad = (mSrc > 23) || (mDst > 23);
            slotLeft = mBad ? 1 : 2;
        end else if (slotLeft > 0) begin
            slotLeft--;
        end
        if (push) begin
            qSrc.push_back(cmd_src);
            qDst.push_back(cmd_dst);
        end
    endtask

    task automatic checkAll();
        logic [23:0] eSrc, eDst;
        bit eDone, eErr;
        eSrc = '0; eDst = '0; eDone = 0; eErr = 0;
        if (slotLeft == 2) eSrc = 24'd1 << mSrc;
        if (slotLeft == 1 && !mBad) begin
            eSrc  = 24'd1 << mSrc;
            eDst  = 24'd1 << mDst;
            eDone = 1;
        end
        if (slotLeft == 1 && mBad) eErr = 1;
        chk("src_out",   32'(src_out),   32'(eSrc));
        chk("dst_in",    32'(dst_in),    32'(eDst));
        chk("xfer_done", 32'(xfer_done), 32'(eDone));
        chk("xfer_err",  32'(xfer_err),  32'(eErr));
        chk("count",     32'(count),     32'(qSrc.size()));
        chk("cmd_ready", 32'(cmd_ready), 32'(qSrc.size() < DEPTH));
        chk("busy",      32'(busy),      32'(slotLeft != 0 || qSrc.size() != 0));
        chk("srcOneHot", 32'($countones(src_out) <= 1), 32'd1);
        chk("dstOneHot", 32'($countones(dst_in) <= 1), 32'd1);
        chk("dstNeedsSrc", 32'(dst_in == '0 || src_out != '0), 32'd1);
    endtask

    // Advance one cycle: model follows the edge, DUT is compared mid-cycle.
    task automatic tick();
        @(posedge clock);
        modelEdge();
        @(negedge clock);
        cyc++;
        checkAll();
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && busy; i++) tick();
        chk("drainIdle", 32'(busy), 32'd0);
    endtask

    initial begin
        int doneCyc[$];
        bit sawFull;

        // Reset held two cycles with a command offered: nothing is pushed.
        clear = 1'b1; cmd_valid = 1'b1; cmd_src = 5'd1; cmd_dst = 5'd2;
        tick();
        tick();
        clear = 1'b0; cmd_valid = 1'b0;
        chk("rstCount", 32'(count), 32'd0);
        chk("rstReady", 32'(cmd_ready), 32'd1);
        chk("rstSrc",   32'(src_out), 32'd0);
        tick();
        chk("rstNoPush", 32'(count), 32'd0);

        // Single transfer PC -> MAR.
        cmd_valid = 1'b1; cmd_src = 5'd20; cmd_dst = 5'd22;
        tick();
        cmd_valid = 1'b0;
        chk("singleQueued", 32'(src_out), 32'd0);
        tick();
        chk("singleDrive",  32'(src_out), 32'h100000);
        chk("singleNoLoad", 32'(dst_in), 32'd0);
        tick();
        chk("singleLoad",   32'(dst_in), 32'h400000);
        chk("singleDone",   32'(xfer_done), 32'd1);
        drain();

        // Back-to-back: R1->Y, R2->R5, Zlow->R7; done pulses 2 cycles apart.
        cmd_valid = 1'b1; cmd_src = 5'd1;  cmd_dst = 5'd21; tick();
        if (xfer_done) doneCyc.push_back(cyc);
        cmd_src = 5'd2;  cmd_dst = 5'd5;  tick();
        if (xfer_done) doneCyc.push_back(cyc);
        cmd_src = 5'd19; cmd_dst = 5'd7;  tick();
        if (xfer_done) doneCyc.push_back(cyc);
        cmd_valid = 1'b0;
        for (int i = 0; i < 20 && doneCyc.size() < 3; i++) begin
            tick();
            if (xfer_done) doneCyc.push_back(cyc);
        end
        chk("b2bPulses", 32'(doneCyc.size()), 32'd3);
        if (doneCyc.size() == 3) begin
            chk("b2bGap1", 32'(doneCyc[1] - doneCyc[0]), 32'd2);
            chk("b2bGap2", 32'(doneCyc[2] - doneCyc[1]), 32'd2);
        end
        drain();

        // Full: keep offering commands until the FIFO fills and refuses.
        sawFull = 0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cmd_src = 5'(i); cmd_dst = 5'(15 - i);
            if (count == 3'(DEPTH) && !cmd_ready) sawFull = 1;
            tick();
        end
        cmd_valid = 1'b0;
        chk("fullSeen", 32'(sawFull), 32'd1);
        drain();

        // Invalid source code followed by a good R4 -> HI transfer.
        cmd_valid = 1'b1; cmd_src = 5'd25; cmd_dst = 5'd3; tick();
        cmd_src = 5'd4; cmd_dst = 5'd16; tick();
        cmd_valid = 1'b0;
        chk("errPulse", 32'(xfer_err), 32'd1);
        chk("errNoSrc", 32'(src_out), 32'd0);
        chk("errNoDst", 32'(dst_in), 32'd0);
        tick();
        chk("postErrDrive", 32'(src_out), 32'h000010);
        tick();
        chk("postErrLoad", 32'(dst_in), 32'h010000);
        chk("postErrDone", 32'(xfer_done), 32'd1);
        drain();

        // Reset during LOAD with two commands still queued.
        cmd_valid = 1'b1; cmd_src = 5'd3; cmd_dst = 5'd8; tick();
        cmd_src = 5'd9;  cmd_dst = 5'd10; tick();
        cmd_src = 5'd11; cmd_dst = 5'd12; tick();
        cmd_valid = 1'b0;
        chk("midLoad",   32'(xfer_done), 32'd1);
        chk("midQueued", 32'(count), 32'd2);
        clear = 1'b1; tick();
        clear = 1'b0;
        chk("midClrSrc",   32'(src_out), 32'd0);
        chk("midClrDst",   32'(dst_in), 32'd0);
        chk("midClrCount", 32'(count), 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("midNoDone", 32'(xfer_done), 32'd0);
        end

        // Random traffic with occasional invalid codes and rare resets.
        for (int i = 0; i < 400; i++) begin
            cmd_valid = ($urandom_range(0, 99) < 60);
            cmd_src   = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 23));
            cmd_dst   = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 23));
            clear     = ($urandom_range(0, 99) == 0);
            tick();
        end
        clear = 1'b0; cmd_valid = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
